// File: rtl/dma_pkg.sv
// dma_pkg: shared state, mode and register-select types
// for the 8237-style transfer engine.
package dma_pkg;

  localparam int LOW_W = 8;

  typedef enum logic [3:0] {
    SI, S0, S1, S2, S3, S4,
    S11, S12, S13, S14,
    S21, S22, S23, S24
  } state_e;

  typedef enum logic [1:0] {
    XF_VERIFY = 2'd0,
    XF_WRITE  = 2'd1,
    XF_READ   = 2'd2,
    XF_RSVD   = 2'd3
  } xfer_e;

  typedef enum logic [1:0] {
    REG_ADDR = 2'd0,
    REG_CNT  = 2'd1,
    REG_MODE = 2'd2,
    REG_CMD  = 2'd3
  } preg_e;

  typedef struct packed {
    xfer_e typ;
    logic  autoinit;
    logic  dec;
  } mode_t;

  function automatic logic is_bus_st(state_e s);
    return s inside {S1, S2, S3, S4,
                     S11, S12, S13, S14,
                     S21, S22, S23, S24};
  endfunction

endpackage

// File: rtl/dma_prio_arbiter.sv
// dma_prio_arbiter: fixed-priority one-hot grant,
// lowest index wins.
module dma_prio_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  assign gnt = req & (~req + N'(1));
  assign any = |req;

endmodule

// File: rtl/dma_xfer_engine.sv
// dma_xfer_engine: channel register file, arbitration,
// S0-S4 / mem2mem FSM and bus strobe generation.
module dma_xfer_engine
  import dma_pkg::*;
#(
  parameter int NCH = 4,
  parameter int AW  = 16,
  parameter int DW  = 8,
  parameter int CW  = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   prog_we,
  input  logic [$clog2(NCH)-1:0] prog_ch,
  input  logic [1:0]             prog_reg,
  input  logic [AW-1:0]          prog_wdata,
  output logic [AW-1:0]          prog_rdata,
  output logic                   busy,
  input  logic [NCH-1:0]         DREQ,
  output logic [NCH-1:0]         DACK,
  output logic                   HRQ,
  input  logic                   HLDA,
  output logic                   AEN,
  output logic                   ADSTB,
  output logic [LOW_W-1:0]       addr_out,
  output logic                   addr_oe,
  input  logic [DW-1:0]          db_in,
  output logic [DW-1:0]          db_out,
  output logic                   db_oe,
  output logic                   IOR_N,
  output logic                   IOW_N,
  output logic                   MEMR_N,
  output logic                   MEMW_N,
  input  logic                   eop_n_in,
  output logic                   eop_n_out
);

  localparam int CHW = $clog2(NCH);

  logic [AW-1:0]  base_addr_q [NCH];
  logic [AW-1:0]  base_addr_d [NCH];
  logic [AW-1:0]  cur_addr_q  [NCH];
  logic [AW-1:0]  cur_addr_d  [NCH];
  logic [CW-1:0]  base_cnt_q  [NCH];
  logic [CW-1:0]  base_cnt_d  [NCH];
  logic [CW-1:0]  cur_cnt_q   [NCH];
  logic [CW-1:0]  cur_cnt_d   [NCH];
  mode_t          mode_q      [NCH];
  mode_t          mode_d      [NCH];
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] tc_q, tc_d;
  logic [NCH-1:0] dack_q, dack_d;
  state_e         state_q, state_d;
  logic [CHW-1:0] chan_q, chan_d;
  logic           m2m_q, m2m_d;
  logic           m2m_req_q, m2m_req_d;
  logic           eop_q, eop_d;
  logic [DW-1:0]  temp_q, temp_d;

  logic [NCH-1:0] req;
  logic [NCH-1:0] gnt;
  logic           gnt_any;
  logic [CHW-1:0] gnt_idx;
  logic [CHW-1:0] act;
  logic [AW-1:0]  act_addr;
  logic [AW-1:0]  next_addr;
  mode_t          act_mode;
  logic           act_fin;
  logic           xf_wr;
  logic           xf_rd;
  logic [AW-1:0]  status;

  assign req = DREQ & ~mask_q;

  dma_prio_arbiter #(.N(NCH)) u_arb (
    .req (req),
    .gnt (gnt),
    .any (gnt_any)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NCH; i++)
      if (gnt[i]) gnt_idx = CHW'(i);
  end

  // mem2mem reads through ch0 and writes through ch1
  always_comb begin
    act = chan_q;
    if (state_q inside {S11, S12, S13, S14})
      act = '0;
    else if (state_q inside {S21, S22, S23, S24})
      act = CHW'(1);
  end

  assign act_addr  = cur_addr_q[act];
  assign act_mode  = mode_q[act];
  assign next_addr = act_mode.dec ? act_addr - AW'(1)
                                  : act_addr + AW'(1);
  assign act_fin   = (cur_cnt_q[act] == '0) || eop_q || !eop_n_in;
  assign xf_wr     = act_mode.typ == XF_WRITE;
  assign xf_rd     = act_mode.typ == XF_READ;

  always_comb begin
    base_addr_d = base_addr_q;
    cur_addr_d  = cur_addr_q;
    base_cnt_d  = base_cnt_q;
    cur_cnt_d   = cur_cnt_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    tc_d        = tc_q;
    dack_d      = dack_q;
    state_d     = state_q;
    chan_d      = chan_q;
    m2m_d       = m2m_q;
    m2m_req_d   = m2m_req_q;
    eop_d       = eop_q;
    temp_d      = temp_q;

    if (state_q == SI && prog_we) begin
      unique case (preg_e'(prog_reg))
        REG_ADDR: begin
          base_addr_d[prog_ch] = prog_wdata;
          cur_addr_d[prog_ch]  = prog_wdata;
        end
        REG_CNT: begin
          base_cnt_d[prog_ch] = CW'(prog_wdata);
          cur_cnt_d[prog_ch]  = CW'(prog_wdata);
          mask_d[prog_ch]     = 1'b0;
        end
        REG_MODE: mode_d[prog_ch] = mode_t'(prog_wdata[3:0]);
        REG_CMD: begin
          m2m_req_d = m2m_req_q | prog_wdata[0];
          tc_d      = tc_q & ~prog_wdata[8 +: NCH];
        end
        default: ;
      endcase
    end

    if (state_q != SI && !eop_n_in)
      eop_d = 1'b1;

    unique case (state_q)
      SI: begin
        if (m2m_req_q) begin
          m2m_req_d = 1'b0;
          m2m_d     = 1'b1;
          dack_d    = '0;
          eop_d     = 1'b0;
          state_d   = S0;
        end else if (gnt_any) begin
          m2m_d   = 1'b0;
          chan_d  = gnt_idx;
          dack_d  = gnt;
          eop_d   = 1'b0;
          state_d = S0;
        end
      end
      S0:  if (HLDA) state_d = m2m_q ? S11 : S1;
      S1:  state_d = S2;
      S2:  state_d = S3;
      S3:  state_d = S4;
      S11: state_d = S12;
      S12: state_d = S13;
      S13: begin
        temp_d  = db_in;
        state_d = S14;
      end
      S14: begin
        cur_addr_d[0] = next_addr;
        cur_cnt_d[0]  = cur_cnt_q[0] - CW'(1);
        state_d       = S21;
      end
      S21: state_d = S22;
      S22: state_d = S23;
      S23: state_d = S24;
      S4, S24: begin
        cur_addr_d[act] = next_addr;
        cur_cnt_d[act]  = cur_cnt_q[act] - CW'(1);
        if (act_fin) begin
          tc_d[act] = 1'b1;
          if (act_mode.autoinit) begin
            cur_addr_d[act] = base_addr_q[act];
            cur_cnt_d[act]  = base_cnt_q[act];
          end else begin
            mask_d[act] = 1'b1;
          end
        end
        state_d = (state_q == S24 && !act_fin) ? S11 : SI;
      end
      default: state_d = SI;
    endcase
  end

  always_comb begin
    AEN       = 1'b0;
    ADSTB     = 1'b0;
    addr_oe   = 1'b0;
    db_oe     = 1'b0;
    db_out    = '0;
    DACK      = '0;
    IOR_N     = 1'b1;
    IOW_N     = 1'b1;
    MEMR_N    = 1'b1;
    MEMW_N    = 1'b1;
    eop_n_out = 1'b1;
    if (is_bus_st(state_q)) begin
      AEN     = 1'b1;
      addr_oe = 1'b1;
    end
    if (state_q inside {S1, S2, S3, S4})
      DACK = dack_q;
    unique case (state_q)
      S1, S11, S21: begin
        ADSTB  = 1'b1;
        db_oe  = 1'b1;
        db_out = DW'(act_addr[AW-1:LOW_W]);
      end
      S2: begin
        IOR_N  = !xf_wr;
        MEMR_N = !xf_rd;
      end
      S3: begin
        IOR_N  = !xf_wr;
        MEMW_N = !xf_wr;
        MEMR_N = !xf_rd;
        IOW_N  = !xf_rd;
      end
      S12, S13: MEMR_N = 1'b0;
      S22: begin
        db_oe  = 1'b1;
        db_out = temp_q;
      end
      S23: begin
        db_oe  = 1'b1;
        db_out = temp_q;
        MEMW_N = 1'b0;
      end
      S4, S24: eop_n_out = !act_fin;
      default: ;
    endcase
  end

  assign addr_out = addr_oe ? act_addr[LOW_W-1:0] : '0;
  assign HRQ      = state_q != SI;
  assign busy     = state_q != SI;

  always_comb begin
    status            = '0;
    status[NCH-1:0]   = tc_q;
    status[8 +: NCH]  = mask_q;
    prog_rdata        = '0;
    unique case (preg_e'(prog_reg))
      REG_ADDR: prog_rdata = cur_addr_q[prog_ch];
      REG_CNT:  prog_rdata = AW'(cur_cnt_q[prog_ch]);
      REG_MODE: prog_rdata = AW'(mode_q[prog_ch]);
      REG_CMD:  prog_rdata = status;
      default:  prog_rdata = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NCH; i++) begin
        base_addr_q[i] <= '0;
        cur_addr_q[i]  <= '0;
        base_cnt_q[i]  <= '0;
        cur_cnt_q[i]   <= '0;
        mode_q[i]      <= '0;
      end
      mask_q    <= '1;
      tc_q      <= '0;
      dack_q    <= '0;
      state_q   <= SI;
      chan_q    <= '0;
      m2m_q     <= 1'b0;
      m2m_req_q <= 1'b0;
      eop_q     <= 1'b0;
      temp_q    <= '0;
    end else begin
      base_addr_q <= base_addr_d;
      cur_addr_q  <= cur_addr_d;
      base_cnt_q  <= base_cnt_d;
      cur_cnt_q   <= cur_cnt_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      tc_q        <= tc_d;
      dack_q      <= dack_d;
      state_q     <= state_d;
      chan_q      <= chan_d;
      m2m_q       <= m2m_d;
      m2m_req_q   <= m2m_req_d;
      eop_q       <= eop_d;
      temp_q      <= temp_d;
    end
  end

endmodule

// File: tb/tb_dma_xfer_engine.sv
// tb_dma_xfer_engine: directed single, priority, autoinit,
// wrap, mem2mem, external EOP and async reset scenarios.
module tb_dma_xfer_engine;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        prog_we;
  logic [1:0]  prog_ch;
  logic [1:0]  prog_reg;
  logic [15:0] prog_wdata;
  logic [15:0] prog_rdata;
  logic        busy;
  logic [3:0]  DREQ;
  logic [3:0]  DACK;
  logic        HRQ;
  logic        HLDA;
  logic        AEN;
  logic        ADSTB;
  logic [7:0]  addr_out;
  logic        addr_oe;
  logic [7:0]  db_in;
  logic [7:0]  db_out;
  logic        db_oe;
  logic        IOR_N;
  logic        IOW_N;
  logic        MEMR_N;
  logic        MEMW_N;
  logic        eop_n_in;
  logic        eop_n_out;

  dma_xfer_engine #(.NCH(4), .AW(16), .DW(8), .CW(16)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .prog_we    (prog_we),
    .prog_ch    (prog_ch),
    .prog_reg   (prog_reg),
    .prog_wdata (prog_wdata),
    .prog_rdata (prog_rdata),
    .busy       (busy),
    .DREQ       (DREQ),
    .DACK       (DACK),
    .HRQ        (HRQ),
    .HLDA       (HLDA),
    .AEN        (AEN),
    .ADSTB      (ADSTB),
    .addr_out   (addr_out),
    .addr_oe    (addr_oe),
    .db_in      (db_in),
    .db_out     (db_out),
    .db_oe      (db_oe),
    .IOR_N      (IOR_N),
    .IOW_N      (IOW_N),
    .MEMR_N     (MEMR_N),
    .MEMW_N     (MEMW_N),
    .eop_n_in   (eop_n_in),
    .eop_n_out  (eop_n_out)
  );

  always #5 CLK = ~CLK;

  // strobe vectors are {IOR_N, IOW_N, MEMR_N, MEMW_N}
  localparam logic [3:0] S2W  = 4'b0111;
  localparam logic [3:0] S3W  = 4'b0110;
  localparam logic [3:0] S2R  = 4'b1101;
  localparam logic [3:0] S3R  = 4'b1001;
  localparam logic [3:0] NONE = 4'b1111;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic [3:0] dack;
  } cyc_t;

  cyc_t       exp_q[$];
  logic [7:0] dat_q[$];
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic prog(input logic [1:0] r, input int ch,
                      input logic [15:0] d);
    prog_we    = 1'b1;
    prog_reg   = r;
    prog_ch    = 2'(ch);
    prog_wdata = d;
    step();
    prog_we    = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] r,
                         input int ch, input logic [15:0] e);
    prog_reg = r;
    prog_ch  = 2'(ch);
    #1;
    chk(tag, prog_rdata, e);
  endtask

  task automatic bus_start(input string tag);
    cyc_t e;
    int   n = 0;
    while (ADSTB !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_adstb"}, ADSTB, 1);
    chk({tag, "_sb"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_hi"}, db_out, e.hi);
      chk({tag, "_lo"}, addr_out, e.lo);
      chk({tag, "_dack"}, DACK, e.dack);
      chk({tag, "_ctl"}, {HRQ, AEN, addr_oe, db_oe}, 4'hF);
    end
  endtask

  task automatic xfer(input string tag, input logic [3:0] s2,
                      input logic [3:0] s3, input logic eop_exp,
                      input logic [3:0] drop, input logic inj);
    bus_start(tag);
    DREQ = DREQ & ~drop;
    step();
    if (inj) begin
      eop_n_in   = 1'b0;
      prog_we    = 1'b1;
      prog_reg   = 2'd0;
      prog_ch    = 2'd2;
      prog_wdata = 16'hBEEF;
    end
    #1;
    chk({tag, "_s2"}, {IOR_N, IOW_N, MEMR_N, MEMW_N}, s2);
    step();
    eop_n_in = 1'b1;
    prog_we  = 1'b0;
    #1;
    chk({tag, "_s3"}, {IOR_N, IOW_N, MEMR_N, MEMW_N}, s3);
    step();
    #1;
    chk({tag, "_s4"}, {IOR_N, IOW_N, MEMR_N, MEMW_N}, NONE);
    chk({tag, "_eop"}, eop_n_out, !eop_exp);
    step();
    chk({tag, "_idle"}, {busy, HRQ}, 2'b00);
  endtask

  task automatic m2m_pair(input string tag, input logic [7:0] d,
                          input logic eop_exp);
    logic [7:0] e;
    bus_start({tag, "_rd"});
    step();
    chk({tag, "_s12"}, MEMR_N, 0);
    step();
    db_in = d;
    dat_q.push_back(d);
    chk({tag, "_s13"}, MEMR_N, 0);
    step();
    step();
    bus_start({tag, "_wr"});
    step();
    e = dat_q.size() != 0 ? dat_q.pop_front() : 8'hxx;
    chk({tag, "_s22"}, {db_oe, db_out}, {1'b1, e});
    step();
    chk({tag, "_s23"}, {MEMW_N, db_out}, {1'b0, e});
    step();
    #1;
    chk({tag, "_eop"}, eop_n_out, !eop_exp);
  endtask

  initial begin
    RESET_N    = 1'b0;
    prog_we    = 1'b0;
    prog_ch    = 2'd0;
    prog_reg   = 2'd0;
    prog_wdata = 16'h0;
    DREQ       = 4'h0;
    HLDA       = 1'b0;
    db_in      = 8'h0;
    eop_n_in   = 1'b1;
    #12;
    chk("rst_ctl", {HRQ, AEN, ADSTB, addr_oe, db_oe, busy}, 6'h0);
    chk("rst_dack", DACK, 4'h0);
    chk("rst_strb", {IOR_N, IOW_N, MEMR_N, MEMW_N, eop_n_out}, 5'h1F);
    chk_reg("rst_addr", 2'd0, 0, 16'h0000);
    chk_reg("rst_stat", 2'd3, 0, 16'h0F00);
    RESET_N = 1'b1;
    step();

    prog(2'd0, 2, 16'h12FE);
    prog(2'd1, 2, 16'h0001);
    prog(2'd2, 2, 16'h0004);
    exp_q.push_back('{8'h12, 8'hFE, 4'b0100});
    exp_q.push_back('{8'h12, 8'hFF, 4'b0100});
    DREQ = 4'b0100;
    HLDA = 1'b1;
    xfer("ch2_a", S2W, S3W, 1'b0, 4'b0000, 1'b0);
    xfer("ch2_b", S2W, S3W, 1'b1, 4'b0100, 1'b0);
    chk_reg("ch2_addr", 2'd0, 2, 16'h1300);
    chk_reg("ch2_cnt", 2'd1, 2, 16'hFFFF);
    chk_reg("ch2_stat", 2'd3, 0, 16'h0F04);

    prog(2'd0, 1, 16'h0040);
    prog(2'd1, 1, 16'h0000);
    prog(2'd2, 1, 16'h0008);
    prog(2'd0, 3, 16'h0080);
    prog(2'd1, 3, 16'h0000);
    prog(2'd2, 3, 16'h0000);
    exp_q.push_back('{8'h00, 8'h40, 4'b0010});
    exp_q.push_back('{8'h00, 8'h80, 4'b1000});
    DREQ = 4'b1010;
    xfer("prio_ch1", S2R, S3R, 1'b1, 4'b0010, 1'b0);
    xfer("prio_ch3", NONE, NONE, 1'b1, 4'b1000, 1'b0);
    chk_reg("prio_stat", 2'd3, 0, 16'h0F0E);

    prog(2'd0, 0, 16'h0100);
    prog(2'd1, 0, 16'h0000);
    prog(2'd2, 0, 16'h0003);
    exp_q.push_back('{8'h01, 8'h00, 4'b0001});
    DREQ = 4'b0001;
    xfer("ai_ch0", NONE, NONE, 1'b1, 4'b0001, 1'b0);
    chk_reg("ai_addr", 2'd0, 0, 16'h0100);
    chk_reg("ai_cnt", 2'd1, 0, 16'h0000);
    chk_reg("ai_stat", 2'd3, 0, 16'h0E0F);
    prog(2'd3, 0, 16'h0F00);
    chk_reg("tc_clr", 2'd3, 0, 16'h0E00);

    prog(2'd0, 3, 16'hFFFF);
    prog(2'd1, 3, 16'h0000);
    prog(2'd2, 3, 16'h0000);
    exp_q.push_back('{8'hFF, 8'hFF, 4'b1000});
    DREQ = 4'b1000;
    xfer("wrap", NONE, NONE, 1'b1, 4'b1000, 1'b0);
    chk_reg("wrap_addr", 2'd0, 3, 16'h0000);
    chk_reg("wrap_stat", 2'd3, 0, 16'h0E08);

    prog(2'd0, 0, 16'h2000);
    prog(2'd2, 0, 16'h0000);
    prog(2'd1, 0, 16'h0001);
    prog(2'd0, 1, 16'h3000);
    prog(2'd1, 1, 16'h0001);
    prog(2'd2, 1, 16'h0000);
    exp_q.push_back('{8'h20, 8'h00, 4'b0000});
    exp_q.push_back('{8'h30, 8'h00, 4'b0000});
    exp_q.push_back('{8'h20, 8'h01, 4'b0000});
    exp_q.push_back('{8'h30, 8'h01, 4'b0000});
    prog(2'd3, 0, 16'h0001);
    m2m_pair("m2m_a", 8'hA5, 1'b0);
    m2m_pair("m2m_b", 8'h5A, 1'b1);
    step();
    chk("m2m_idle", busy, 0);
    chk_reg("m2m_dst", 2'd0, 1, 16'h3002);
    chk_reg("m2m_src", 2'd0, 0, 16'h2002);
    chk_reg("m2m_stat", 2'd3, 0, 16'h0E0A);

    prog(2'd0, 2, 16'h0500);
    prog(2'd1, 2, 16'h0005);
    prog(2'd2, 2, 16'h0004);
    exp_q.push_back('{8'h05, 8'h00, 4'b0100});
    DREQ = 4'b0100;
    xfer("eop", S2W, S3W, 1'b1, 4'b0100, 1'b1);
    chk_reg("eop_cnt", 2'd1, 2, 16'h0004);
    chk_reg("eop_addr", 2'd0, 2, 16'h0501);
    chk_reg("eop_stat", 2'd3, 0, 16'h0E0E);

    prog(2'd0, 3, 16'h4455);
    prog(2'd1, 3, 16'h0002);
    prog(2'd2, 3, 16'h0004);
    exp_q.push_back('{8'h44, 8'h55, 4'b1000});
    DREQ = 4'b1000;
    bus_start("rst_mid");
    step();
    step();
    chk("rst_mid_s3", {IOR_N, IOW_N, MEMR_N, MEMW_N}, S3W);
    RESET_N = 1'b0;
    #1;
    chk("rst_mid_ctl", {HRQ, AEN, ADSTB, addr_oe, db_oe, busy}, 6'h0);
    chk("rst_mid_dack", DACK, 4'h0);
    chk("rst_mid_strb", {IOR_N, IOW_N, MEMR_N, MEMW_N, eop_n_out},
        5'h1F);
    chk_reg("rst_mid_addr", 2'd0, 3, 16'h0000);
    chk_reg("rst_mid_stat", 2'd3, 0, 16'h0F00);
    DREQ = 4'h0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
